// File: rtl/fftc_pipe_pkg.sv
// Shared constants and helpers for the elastic FFT pipeline register.
package fftc_pipe_pkg;

  localparam int D_WIDTH_DEF = 64;
  localparam int LANES_DEF   = 16;
  localparam int DEPTH_MAX   = 16;

  localparam logic [D_WIDTH_DEF*LANES_DEF-1:0] D_ZERO = {(D_WIDTH_DEF*LANES_DEF){1'b0}};

  function automatic logic [D_WIDTH_DEF-1:0] lane(
    input logic [D_WIDTH_DEF*LANES_DEF-1:0] vec,
    input int                               k
  );
    return vec[k*D_WIDTH_DEF +: D_WIDTH_DEF];
  endfunction

  function automatic logic [4:0] popcount16(input logic [DEPTH_MAX-1:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < DEPTH_MAX; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/fftc_pipe_slot.sv
// One elastic stage: a valid bit plus a data word, loading only real transfers.
module fftc_pipe_slot
  import fftc_pipe_pkg::*;
#(
  parameter int W = D_WIDTH_DEF * LANES_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         up_v,
  input  logic [W-1:0] up_d,
  input  logic         dn_rdy,
  output logic         v,
  output logic [W-1:0] d,
  output logic         rdy,
  output logic         v_nxt
);

  logic         v_q, v_d;
  logic [W-1:0] d_q, d_d;

  assign rdy   = ~v_q | dn_rdy;
  assign v     = v_q;
  assign d     = d_q;
  assign v_nxt = v_d;

  // Next state: flush clears valid only; data moves only on a valid upstream word.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (flush) begin
      v_d = 1'b0;
    end else if (rdy) begin
      v_d = up_v;
      if (up_v) begin
        d_d = up_d;
      end else begin
        d_d = d_q;
      end
    end else begin
      v_d = v_q;
    end
  end

  // Stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= 1'b0;
      d_q <= {W{1'b0}};
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

endmodule

// File: rtl/fftc_pipe_elastic.sv
// Multi-lane, DEPTH-stage elastic pipeline register with valid/ready backpressure,
// bubble collapsing, synchronous flush and a registered occupancy count.
module fftc_pipe_elastic
  import fftc_pipe_pkg::*;
#(
  parameter  int D_WIDTH = D_WIDTH_DEF,
  parameter  int LANES   = LANES_DEF,
  parameter  int DEPTH   = 2,
  localparam int OCC_W   = $clog2(DEPTH + 1),
  localparam int DW      = LANES * D_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [OCC_W-1:0] occupancy
);

  logic [DEPTH:0]          rdy_s;
  logic [DEPTH-1:0]        v_s;
  logic [DEPTH-1:0]        v_nxt_s;
  logic [DEPTH-1:0]        up_v_s;
  logic [DW-1:0]           up_d_s [DEPTH];
  logic [DW-1:0]           d_s    [DEPTH];
  logic [DEPTH_MAX-1:0]    v_pad_s;
  logic [OCC_W-1:0]        occ_q, occ_d;

  assign rdy_s[DEPTH] = out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign up_v_s[i] = in_valid;
      assign up_d_s[i] = in_data;
    end else begin : g_body
      assign up_v_s[i] = v_s[i-1];
      assign up_d_s[i] = d_s[i-1];
    end

    fftc_pipe_slot #(.W(DW)) u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .flush  (flush),
      .up_v   (up_v_s[i]),
      .up_d   (up_d_s[i]),
      .dn_rdy (rdy_s[i+1]),
      .v      (v_s[i]),
      .d      (d_s[i]),
      .rdy    (rdy_s[i]),
      .v_nxt  (v_nxt_s[i])
    );
  end

  assign in_ready  = rdy_s[0] & ~flush;
  assign out_valid = v_s[DEPTH-1];
  assign out_data  = d_s[DEPTH-1];
  assign occupancy = occ_q;

  // Count from next-state valids so the registered count tracks v[] in the same cycle.
  always_comb begin
    v_pad_s              = {DEPTH_MAX{1'b0}};
    v_pad_s[DEPTH-1:0]   = v_nxt_s;
    occ_d                = OCC_W'(popcount16(v_pad_s));
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= {OCC_W{1'b0}};
    end else begin
      occ_q <= occ_d;
    end
  end

endmodule

// File: tb/tb_fftc_pipe_elastic.sv
// Directed and random checks of the elastic pipeline at DEPTH 3, 1 and 4.
module tb_fftc_pipe_elastic;
  import fftc_pipe_pkg::*;

  localparam int DW = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;

  logic          in_ready3, out_valid3, in_ready1, out_valid1, in_ready4, out_valid4;
  logic [DW-1:0] out_data3, out_data1, out_data4;
  logic [1:0]    occ3;
  logic [0:0]    occ1;
  logic [2:0]    occ4;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  fftc_pipe_elastic #(.DEPTH(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready3),
    .in_data(in_data), .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
    .occupancy(occ3));
  fftc_pipe_elastic #(.DEPTH(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .occupancy(occ1));
  fftc_pipe_elastic #(.DEPTH(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .occupancy(occ4));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    for (int k = 0; k < 16; k++) chk(tag, lane(got, k), lane(exp, k));
  endtask

  function automatic logic [DW-1:0] word(input int n);
    logic [DW-1:0] w;
    for (int k = 0; k < 16; k++) w[k*64 +: 64] = 64'h100 * 64'(n) + 64'(k);
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  int q3[$], q1[$], q4[$];
  int cnt1, cnt4, seq, n, got_cnt;
  logic [DW-1:0] junk;

  initial begin
    junk = {DW{1'b1}};
    do_reset();
    #1;
    chk("rst_out_valid", 64'(out_valid3), 64'd0);
    chk_word("rst_out_data", out_data3, D_ZERO);
    chk("rst_occ", 64'(occ3), 64'd0);
    chk("rst_in_ready", 64'(in_ready3), 64'd1);

    // Streaming, DEPTH=3: word n appears in window n+3
    out_ready = 1'b1;
    for (int c = 0; c < 13; c++) begin
      tick();
      in_valid = (c < 10);
      in_data  = (c < 10) ? word(c) : junk;
      #1;
      if (c < 10) chk("stream_in_ready", 64'(in_ready3), 64'd1);
      chk("stream_out_valid", 64'(out_valid3), 64'(c >= 3));
      if (c >= 3) chk_word("stream_data", out_data3, word(c - 3));
    end

    // Stall fill: A,B,C accepted, D refused, A held stable
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      in_valid = 1'b1; in_data = word(100 + i);
      #1;
      chk("fill_in_ready", 64'(in_ready3), 64'(i < 3));
    end
    chk("fill_occ", 64'(occ3), 64'd3);
    chk("fill_out_valid", 64'(out_valid3), 64'd1);
    for (int i = 0; i < 2; i++) begin
      tick();
      #1;
      chk_word("fill_stable", out_data3, word(100));
      chk("fill_hold_ready", 64'(in_ready3), 64'd0);
    end
    q3 = {100, 101, 102, 103};
    tick();
    out_ready = 1'b1;
    #1;
    got_cnt = 0;
    for (int c = 0; c < 20 && q3.size() > 0; c++) begin
      if (out_valid3) begin
        n = q3.pop_front();
        chk_word("drain_data", out_data3, word(n));
      end
      if (in_valid && in_ready3) got_cnt++;
      tick();
      if (got_cnt > 0) in_valid = 1'b0;
      #1;
    end
    chk("drain_d_accepted", 64'(got_cnt), 64'd1);
    chk("drain_left", 64'(q3.size()), 64'd0);
    chk("drain_occ", 64'(occ3), 64'd0);

    // Bubbles: 1,0,1,0 in -> same pattern out after 3, data held in gaps
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      in_valid = (c == 0 || c == 2);
      in_data  = in_valid ? word(200 + c) : junk;
      #1;
      chk("bubble_valid", 64'(out_valid3), 64'(c == 3 || c == 5));
      if (c == 3 || c == 4) chk_word("bubble_d0", out_data3, word(200));
      if (c == 5 || c == 6 || c == 7) chk_word("bubble_d2", out_data3, word(202));
    end

    // Flush: X,Y held, Z offered with flush and dropped
    do_reset();
    for (int i = 0; i < 2; i++) begin
      tick();
      in_valid = 1'b1; in_data = word(300 + i);
      #1;
    end
    tick();
    #1;
    chk("flush_pre_occ", 64'(occ3), 64'd2);
    flush = 1'b1; in_data = word(302);
    #1;
    chk("flush_in_ready", 64'(in_ready3), 64'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_occ", 64'(occ3), 64'd0);
    chk("flush_out_valid", 64'(out_valid3), 64'd0);
    out_ready = 1'b1;
    got_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      #1;
      if (out_valid3) got_cnt++;
    end
    chk("flush_nothing_out", 64'(got_cnt), 64'd0);

    // Asynchronous reset with a full pipe, no edge in between
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      in_valid = 1'b1; in_data = word(400 + i);
      #1;
    end
    chk("arst_pre_occ", 64'(occ3), 64'd3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid3), 64'd0);
    chk_word("arst_out_data", out_data3, D_ZERO);
    chk("arst_occ", 64'(occ3), 64'd0);
    rst_n = 1'b1;

    // Random traffic with scoreboards on DEPTH=1 and DEPTH=4
    do_reset();
    q1.delete(); q4.delete();
    cnt1 = 0; cnt4 = 0; seq = 1000;
    for (int c = 0; c < 400 + 8; c++) begin
      tick();
      in_valid  = (c < 400) ? 1'($urandom_range(0, 1)) : 1'b0;
      out_ready = (c < 400) ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data   = word(seq);
      #1;
      chk("rnd1_occ", 64'(occ1), 64'(cnt1));
      chk("rnd4_occ", 64'(occ4), 64'(cnt4));
      if (out_valid1 && out_ready) begin
        if (q1.size() == 0) chk("rnd1_extra", 64'(q1.size()), 64'd1);
        else begin n = q1.pop_front(); chk_word("rnd1_data", out_data1, word(n)); end
        cnt1--;
      end
      if (in_valid && in_ready1) begin q1.push_back(seq); cnt1++; end
      if (out_valid4 && out_ready) begin
        if (q4.size() == 0) chk("rnd4_extra", 64'(q4.size()), 64'd1);
        else begin n = q4.pop_front(); chk_word("rnd4_data", out_data4, word(n)); end
        cnt4--;
      end
      if (in_valid && in_ready4) begin q4.push_back(seq); cnt4++; end
      seq++;
    end
    chk("rnd1_left", 64'(q1.size()), 64'd0);
    chk("rnd4_left", 64'(q4.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
